csr_trap_file: RTL

//  Parametrised machine-mode CSR file with hardware trap entry/exit, interrupt pending logic and writable counters.

---
 rtl/csr_trap_file.sv | 303 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/csr_trap_file.sv
// -----------------------------------------------------------------------------
// csr_trap_file
//   Machine-mode CSR file that sits beside writeback. EXE reads CSRs through a
//   combinational port. WB commits CSR writes, trap entry and mret. The block
//   returns the trap redirect target, the mret target and a registered
//   interrupt request to the pipe controller.
//
//   Optional feature: define CSR_SMODE_EN to implement medeleg, mideleg,
//   stvec, sscratch, sepc, scause and satp as plain R/W registers, and to set
//   misa.S. Without the macro those addresses read 0 and ignore writes.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   raddr_i / rdata_o        CSR read address / combinational read data
//   we_i, waddr_i, wdata_i   CSR write commit from WB
//   instret_incr_i           retire pulse for minstret
//   trap_valid_i, trap_cause_i, trap_pc_i, trap_val_i   trap entry
//   mret_i                   mret retires this cycle
//   irq_ext_i, irq_timer_i, irq_sw_i   asynchronous interrupt lines
//   irq_pending_o, irq_cause_o         registered interrupt request/cause
//   trap_vector_o            redirect target for a trap
//   mepc_o                   mret target
//
// All commit-side inputs are single-cycle qualifiers: there is no back-pressure,
// so every asserted strobe is consumed on the next rising edge of clk_i.
// -----------------------------------------------------------------------------
module csr_trap_file #(
    parameter int              XLEN      = 32,
    parameter int              CNT_WIDTH = 64,
    parameter int              NUM_PMP   = 4,
    parameter logic [XLEN-1:0] HART_ID   = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [11:0]     raddr_i,
    output logic [XLEN-1:0] rdata_o,
    input  logic            we_i,
    input  logic [11:0]     waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            instret_incr_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_val_i,
    input  logic            mret_i,
    input  logic            irq_ext_i,
    input  logic            irq_timer_i,
    input  logic            irq_sw_i,
    output logic            irq_pending_o,
    output logic [XLEN-1:0] irq_cause_o,
    output logic [XLEN-1:0] trap_vector_o,
    output logic [XLEN-1:0] mepc_o
);

    localparam int HI_W = CNT_WIDTH - 32;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINH = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_PMPCFG0   = 12'h3A0;
    localparam logic [11:0] CSR_PMPADDR0  = 12'h3B0;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

`ifdef CSR_SMODE_EN
    localparam int NUM_S = 7;
    // medeleg, mideleg, stvec, sscratch, sepc, scause, satp
    localparam logic [11:0] S_ADDR [NUM_S] = '{12'h302, 12'h303, 12'h105, 12'h140,
                                               12'h141, 12'h142, 12'h180};
    localparam logic [25:0] MISA_EXT = 26'h0041100;
`else
    localparam logic [25:0] MISA_EXT = 26'h0001100;
`endif
    localparam logic [XLEN-1:0] MISA_VAL = {2'b01, 4'b0000, MISA_EXT};

    // ------------------------------------------------------------------ state
    logic                 mst_mie_q, mst_mpie_q;
    logic [XLEN-1:0]      mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [XLEN-1:0]      pmpcfg0_q;
    logic [XLEN-1:0]      pmpaddr_q [NUM_PMP];
    logic [1:0]           inhibit_q;        // [0] mcycle, [1] minstret
    logic [CNT_WIDTH-1:0] mcycle_q, minstret_q;
    logic [2:0]           irq_sync1_q, irq_sync2_q;  // {ext, timer, sw}
    logic                 irq_pending_q;
    logic [XLEN-1:0]      irq_cause_q;
`ifdef CSR_SMODE_EN
    logic [XLEN-1:0]      s_csr_q [NUM_S];
`endif

    // ------------------------------------------------------------ decoding
    function automatic logic is_writable(input logic [11:0] a);
        logic w;
        w = 1'b0;
        case (a)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MCOUNTINH, CSR_MSCRATCH,
            CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_PMPCFG0,
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: w = 1'b1;
            default: begin
                for (int i = 0; i < NUM_PMP; i++)
                    if (a == CSR_PMPADDR0 + 12'(i)) w = 1'b1;
`ifdef CSR_SMODE_EN
                for (int i = 0; i < NUM_S; i++)
                    if (a == S_ADDR[i]) w = 1'b1;
`endif
            end
        endcase
        return w;
    endfunction

    logic wr_mstatus, wr_mepc, wr_mcause, wr_mtval;
    logic wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;

    assign wr_mstatus   = we_i && (waddr_i == CSR_MSTATUS);
    assign wr_mepc      = we_i && (waddr_i == CSR_MEPC);
    assign wr_mcause    = we_i && (waddr_i == CSR_MCAUSE);
    assign wr_mtval     = we_i && (waddr_i == CSR_MTVAL);
    assign wr_mcycle    = we_i && (waddr_i == CSR_MCYCLE);
    assign wr_mcycleh   = we_i && (waddr_i == CSR_MCYCLEH);
    assign wr_minstret  = we_i && (waddr_i == CSR_MINSTRET);
    assign wr_minstreth = we_i && (waddr_i == CSR_MINSTRETH);

    // ------------------------------------------------------- interrupt logic
    logic [XLEN-1:0] mip_val, irq_enabled, irq_cause_next;

    assign mip_val     = XLEN'({irq_sync2_q[2], 3'b000, irq_sync2_q[1], 3'b000,
                                irq_sync2_q[0], 3'b000});
    assign irq_enabled = mip_val & mie_q;

    // Fixed priority MEI > MSI > MTI.
    always_comb begin
        irq_cause_next = '0;
        if (irq_enabled[11])     irq_cause_next = {1'b1, (XLEN-1)'(11)};
        else if (irq_enabled[3]) irq_cause_next = {1'b1, (XLEN-1)'(3)};
        else if (irq_enabled[7]) irq_cause_next = {1'b1, (XLEN-1)'(7)};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_sync1_q   <= '0;
            irq_sync2_q   <= '0;
            irq_pending_q <= 1'b0;
            irq_cause_q   <= '0;
        end else begin
            irq_sync1_q   <= {irq_ext_i, irq_timer_i, irq_sw_i};
            irq_sync2_q   <= irq_sync1_q;
            irq_pending_q <= mst_mie_q & (|irq_enabled);
            irq_cause_q   <= irq_cause_next;
        end
    end

    assign irq_pending_o = irq_pending_q;
    assign irq_cause_o   = irq_cause_q;

    // Vectored mode only offsets for interrupts; the pending cause is the one
    // the controller will take.
    always_comb begin
        trap_vector_o = {mtvec_q[XLEN-1:2], 2'b00};
        if (mtvec_q[1:0] == 2'b01 && irq_pending_q)
            trap_vector_o = {mtvec_q[XLEN-1:2], 2'b00} + {irq_cause_q[XLEN-3:0], 2'b00};
    end

    assign mepc_o = mepc_q;

    // ------------------------------------------------ mstatus / trap state
    // Trap entry beats mret, which beats a software write of mstatus.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            if (trap_valid_i) begin
                mst_mpie_q <= mst_mie_q;
                mst_mie_q  <= 1'b0;
            end else if (mret_i) begin
                mst_mie_q  <= mst_mpie_q;
                mst_mpie_q <= 1'b1;
            end else if (wr_mstatus) begin
                mst_mie_q  <= wdata_i[3];
                mst_mpie_q <= wdata_i[7];
            end

            if (trap_valid_i)  mepc_q <= {trap_pc_i[XLEN-1:2], 2'b00};
            else if (wr_mepc)  mepc_q <= wdata_i;

            if (trap_valid_i)   mcause_q <= trap_cause_i;
            else if (wr_mcause) mcause_q <= wdata_i;

            if (trap_valid_i)  mtval_q <= trap_val_i;
            else if (wr_mtval) mtval_q <= wdata_i;
        end
    end

    // ------------------------------------------------- plain R/W registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            pmpcfg0_q  <= '0;
            inhibit_q  <= '0;
            for (int i = 0; i < NUM_PMP; i++) pmpaddr_q[i] <= '0;
        end else if (we_i) begin
            case (waddr_i)
                CSR_MIE:       mie_q      <= wdata_i;
                // Reserved modes 2/3 collapse to direct.
                CSR_MTVEC:     mtvec_q    <= {wdata_i[XLEN-1:2],
                                              wdata_i[1] ? 2'b00 : wdata_i[1:0]};
                CSR_MSCRATCH:  mscratch_q <= wdata_i;
                CSR_PMPCFG0:   pmpcfg0_q  <= wdata_i;
                CSR_MCOUNTINH: inhibit_q  <= {wdata_i[2], wdata_i[0]};
                default: begin
                    for (int i = 0; i < NUM_PMP; i++)
                        if (waddr_i == CSR_PMPADDR0 + 12'(i)) pmpaddr_q[i] <= wdata_i;
                end
            endcase
        end
    end

`ifdef CSR_SMODE_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_S; i++) s_csr_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_S; i++)
                if (we_i && waddr_i == S_ADDR[i]) s_csr_q[i] <= wdata_i;
        end
    end
`endif

    // --------------------------------------------------------------- counters
    // A half written by software suppresses the increment for that cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (wr_mcycle)         mcycle_q[31:0]          <= wdata_i;
            else if (wr_mcycleh)   mcycle_q[CNT_WIDTH-1:32] <= wdata_i[HI_W-1:0];
            else if (!inhibit_q[0]) mcycle_q               <= mcycle_q + CNT_WIDTH'(1);

            if (wr_minstret)       minstret_q[31:0]          <= wdata_i;
            else if (wr_minstreth) minstret_q[CNT_WIDTH-1:32] <= wdata_i[HI_W-1:0];
            else if (instret_incr_i && !inhibit_q[1])
                                   minstret_q                <= minstret_q + CNT_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------- read port
    logic [XLEN-1:0] read_val;

    always_comb begin
        read_val = '0;
        case (raddr_i)
            CSR_MSTATUS:   read_val = XLEN'({2'b11, 3'b000, mst_mpie_q, 3'b000,
                                             mst_mie_q, 3'b000});
            CSR_MISA:      read_val = MISA_VAL;
            CSR_MIE:       read_val = mie_q;
            CSR_MTVEC:     read_val = mtvec_q;
            CSR_MCOUNTINH: read_val = XLEN'({inhibit_q[1], 1'b0, inhibit_q[0]});
            CSR_MSCRATCH:  read_val = mscratch_q;
            CSR_MEPC:      read_val = mepc_q;
            CSR_MCAUSE:    read_val = mcause_q;
            CSR_MTVAL:     read_val = mtval_q;
            CSR_MIP:       read_val = mip_val;
            CSR_PMPCFG0:   read_val = pmpcfg0_q;
            CSR_MCYCLE, CSR_CYCLE:       read_val = mcycle_q[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:     read_val = XLEN'(mcycle_q[CNT_WIDTH-1:32]);
            CSR_MINSTRET, CSR_INSTRET:   read_val = minstret_q[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: read_val = XLEN'(minstret_q[CNT_WIDTH-1:32]);
            CSR_MHARTID:   read_val = HART_ID;
            default: begin
                for (int i = 0; i < NUM_PMP; i++)
                    if (raddr_i == CSR_PMPADDR0 + 12'(i)) read_val = pmpaddr_q[i];
`ifdef CSR_SMODE_EN
                for (int i = 0; i < NUM_S; i++)
                    if (raddr_i == S_ADDR[i]) read_val = s_csr_q[i];
`endif
            end
        endcase
    end

    // Same-cycle write to the address being read forwards the write data.
    assign rdata_o = (we_i && (waddr_i == raddr_i) && is_writable(waddr_i)) ? wdata_i
                                                                           : read_val;

endmodule
